// File: rtl/dmem_if.sv
// Request/response bundle between a load/store initiator and the data-memory responder.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface dmem_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency RISC-V data memory: one request in flight, byte/half/word loads and stores,
// misaligned or illegal accesses answered with rsp_err and no memory side effect.
module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic       busy,
  output logic [1:0] dbg_state_o
);
  localparam int WORDS = 1 << (DM_ADDRESS - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  accept, fire;
  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  rsp_err_q;
  logic [31:0]           mem_q [WORDS];

  logic [31:0] word_rd, load_data, store_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is loaded with LATENCY-1 so the WAIT->RESP edge lands exactly LATENCY edges after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = 3'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          fire    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign word_rd   = mem_q[addr_q[DM_ADDRESS-1:2]];
  assign lane_byte = word_rd[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    err        = 1'b0;
    load_data  = '0;
    store_word = word_rd;
    if (we_q) begin
      case (funct3_q)
        3'b000: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        3'b001: begin
          if (addr_q[0]) err = 1'b1;
          else store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
        3'b010: begin
          if (addr_q[1:0] != 2'b00) err = 1'b1;
          else store_word = wdata_q[31:0];
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3_q)
        3'b000: load_data = {{24{lane_byte[7]}}, lane_byte};
        3'b001: begin
          if (addr_q[0]) err = 1'b1;
          else load_data = {{16{lane_half[15]}}, lane_half};
        end
        3'b010: begin
          if (addr_q[1:0] != 2'b00) err = 1'b1;
          else load_data = word_rd;
        end
        3'b100: load_data = {24'd0, lane_byte};
        3'b101: begin
          if (addr_q[0]) err = 1'b1;
          else load_data = {16'd0, lane_half};
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
      end
      rsp_valid_q <= fire;
      rsp_err_q   <= fire & err;
      rsp_rdata_q <= (fire && !we_q && !err) ? DATA_W'(load_data) : '0;
    end
  end

  // Storage is deliberately outside the reset domain; a reset only stops a pending commit via the FSM.
  always_ff @(posedge clk) begin
    if (fire && we_q && !err) mem_q[addr_q[DM_ADDRESS-1:2]] <= store_word;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance for data-path vectors and a LATENCY=1 instance
// for back-to-back throughput, each with its own expected-response queue and monitor.
module tb_dmem_responder;
  logic       clk;
  logic       reset;
  logic       busy2, busy1;
  logic [1:0] dbg2, dbg1;
  int         cyc;
  int         n_checks;
  int         n_errors;

  logic [32:0] exp_q2[$];
  int          acc_q2[$];
  logic [32:0] exp_q1[$];
  int          acc_q1[$];

  dmem_if #(.DM_ADDRESS(9), .DATA_W(32)) bus2 ();
  dmem_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .busy(busy2), .dbg_state_o(dbg2)
  );
  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1), .dbg_state_o(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    logic [32:0] e;
    int a;
    if (reset) begin
      if (bus2.rsp_valid) begin
        check("rsp_expected2", 64'(exp_q2.size() > 0), 64'd1);
        if (exp_q2.size() > 0) begin
          e = exp_q2.pop_front();
          a = acc_q2.pop_front();
          check("rsp_err2", 64'(bus2.rsp_err), 64'(e[32]));
          check("rsp_rdata2", 64'(bus2.rsp_rdata), 64'(e[31:0]));
          check("latency2", 64'(cyc - a), 64'd2);
        end
      end else begin
        check("idle_zero2", 64'({bus2.rsp_err, bus2.rsp_rdata}), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    int a;
    if (reset && bus1.rsp_valid) begin
      check("rsp_expected1", 64'(exp_q1.size() > 0), 64'd1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        a = acc_q1.pop_front();
        check("rsp_err1", 64'(bus1.rsp_err), 64'(e[32]));
        check("rsp_rdata1", 64'(bus1.rsp_rdata), 64'(e[31:0]));
        check("latency1", 64'(cyc - a), 64'd1);
      end
    end
  end

  // drivers
  task automatic wait_ready2();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus2.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait2", 64'(bus2.req_ready), 64'd1);
  endtask

  task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic exp_err, input logic [31:0] exp_rd);
    wait_ready2();
    bus2.req_valid  = 1'b1;
    bus2.req_we     = we;
    bus2.req_addr   = addr;
    bus2.req_wdata  = wd;
    bus2.req_funct3 = f3;
    exp_q2.push_back({exp_err, exp_rd});
    acc_q2.push_back(cyc + 1);
    @(negedge clk);
    bus2.req_valid  = 1'b0;
    bus2.req_wdata  = 32'h0BAD_0BAD;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q2.size() > 0 || exp_q1.size() > 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain2", 64'(exp_q2.size()), 64'd0);
    check("drain1", 64'(exp_q1.size()), 64'd0);
  endtask

  initial begin
    int last, acc_n, t;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.req_funct3 = 3'd0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_funct3 = 3'd0;

    repeat (2) @(negedge clk);
    bus2.req_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus2.req_ready), 64'd1);
    check("rst_busy", 64'(busy2), 64'd0);
    check("rst_rsp", 64'({bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}), 64'd0);
    check("rst_state", 64'(dbg2), 64'd0);
    bus2.req_valid = 1'b0;
    reset = 1'b1;

    // SW then ready stays low through the RESP cycle
    issue(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0);
    check("sw_ready_k", 64'(bus2.req_ready), 64'd0);
    @(negedge clk);
    check("sw_ready_k1", 64'(bus2.req_ready), 64'd0);
    @(negedge clk);
    check("sw_ready_k2", 64'(bus2.req_ready), 64'd0);
    check("sw_busy_k2", 64'(busy2), 64'd1);
    @(negedge clk);
    check("sw_ready_k3", 64'(bus2.req_ready), 64'd1);
    check("sw_busy_k3", 64'(busy2), 64'd0);

    issue(1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 9'h013, 32'h0, 3'b000, 1'b0, 32'hFFFFFFDE);
    issue(1'b0, 9'h013, 32'h0, 3'b100, 1'b0, 32'h000000DE);
    issue(1'b0, 9'h012, 32'h0, 3'b001, 1'b0, 32'hFFFFDEAD);
    issue(1'b0, 9'h010, 32'h0, 3'b101, 1'b0, 32'h0000BEEF);

    issue(1'b1, 9'h011, 32'h00000055, 3'b000, 1'b0, 32'h0);
    issue(1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'hDEAD55EF);
    issue(1'b1, 9'h012, 32'h00001234, 3'b001, 1'b0, 32'h0);
    issue(1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'h123455EF);

    issue(1'b0, 9'h012, 32'h0, 3'b010, 1'b1, 32'h0);
    issue(1'b0, 9'h011, 32'h0, 3'b001, 1'b1, 32'h0);
    issue(1'b0, 9'h010, 32'h0, 3'b011, 1'b1, 32'h0);
    issue(1'b1, 9'h010, 32'hFFFFFFFF, 3'b100, 1'b1, 32'h0);
    issue(1'b1, 9'h011, 32'hFFFFFFFF, 3'b001, 1'b1, 32'h0);
    issue(1'b1, 9'h014, 32'hFFFFFFFF, 3'b011, 1'b1, 32'h0);
    issue(1'b1, 9'h012, 32'hFFFFFFFF, 3'b010, 1'b1, 32'h0);
    issue(1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 32'h123455EF);

    issue(1'b0, 9'h010, 32'h0, 3'b000, 1'b0, 32'hFFFFFFEF);
    issue(1'b0, 9'h011, 32'h0, 3'b000, 1'b0, 32'h00000055);
    issue(1'b0, 9'h010, 32'h0, 3'b001, 1'b0, 32'h000055EF);
    issue(1'b0, 9'h012, 32'h0, 3'b101, 1'b0, 32'h00001234);

    // store aborted by reset before its commit edge
    issue(1'b1, 9'h020, 32'hA5A50F0F, 3'b010, 1'b0, 32'h0);
    wait_ready2();
    bus2.req_valid  = 1'b1;
    bus2.req_we     = 1'b1;
    bus2.req_addr   = 9'h020;
    bus2.req_wdata  = 32'h11111111;
    bus2.req_funct3 = 3'b010;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    check("abort_accepted", 64'(busy2), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rst_ready", 64'(bus2.req_ready), 64'd1);
    check("abort_rst_busy", 64'(busy2), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'({bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata}), 64'd0);
    end
    reset = 1'b1;
    #1;
    check("abort_ready_release", 64'(bus2.req_ready), 64'd1);
    issue(1'b0, 9'h020, 32'h0, 3'b010, 1'b0, 32'hA5A50F0F);
    drain();

    // LATENCY=1 with req_valid held high
    @(negedge clk);
    bus1.req_valid  = 1'b1;
    bus1.req_we     = 1'b1;
    bus1.req_addr   = 9'h004;
    bus1.req_wdata  = 32'hCAFEF00D;
    bus1.req_funct3 = 3'b010;
    last  = -1;
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus1.req_ready) begin
        if (last >= 0) check("accept_spacing", 64'(cyc + 1 - last), 64'd3);
        exp_q1.push_back(33'd0);
        acc_q1.push_back(cyc + 1);
        last = cyc + 1;
        acc_n++;
      end else begin
        check("busy_between", 64'(busy1), 64'd1);
      end
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    check("accept_count", 64'(acc_n), 64'd4);
    t = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width; storage = 2^(DM_ADDRESS-2) 32-bit words, little-endian.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 Parameter LATENCY, default 2, edges from accept to response; legal range 1..7.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  DM_ADDRESS  byte address.
REQ-010 req_wdata  input  DATA_W  store data; lane 0 is aligned to bits [7:0].
REQ-011 req_funct3  input  3  RISC-V load/store funct3.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  DATA_W  load result; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned access or illegal funct3; qualified by rsp_valid.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The module SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 in IDLE and 0 in all other states.
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready; the state then goes IDLE->WAIT.
REQ-019 On accept, the module SHALL register we, addr, wdata and funct3, and load the counter with LATENCY-1.
REQ-020 In WAIT, when counter==0 the next state SHALL be RESP; otherwise the counter decrements by 1.
REQ-021 For a request accepted at edge k, rsp_valid SHALL be high during exactly the cycle following edge k+LATENCY.
REQ-022 RESP SHALL return to IDLE unconditionally on the next edge; the earliest next accept is edge k+LATENCY+2.
REQ-023 Changes on the request inputs while in WAIT or RESP SHALL be ignored.
REQ-024 Loads SHALL decode as: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
REQ-025 Stores SHALL decode as: 000 SB, 001 SH, 010 SW.
REQ-026 SB SHALL write only byte lane addr[1:0]; SH SHALL write only half addr[1]; SW SHALL write the full word; other bytes stay unchanged.
REQ-027 The word index SHALL be addr[DM_ADDRESS-1:2].
REQ-028 Misalignment SHALL be defined as: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-029 Misaligned accesses and illegal funct3 (loads 011/110/111; stores other than 000/001/010) SHALL set rsp_err=1 and rsp_rdata=0.
REQ-030 An erroring store SHALL NOT modify memory.
REQ-031 A valid store SHALL commit to storage on edge k+LATENCY, the same edge that raises rsp_valid.
REQ-032 A load accepted after that commit edge SHALL return the new data.
REQ-033 rsp_rdata and rsp_err SHALL be registered and SHALL hold 0 whenever rsp_valid=0.

Reset
REQ-034 While reset=0, the module SHALL force: state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0.
REQ-035 Reset asserted mid-transaction SHALL abort it: no response, and no memory write if asserted before the commit edge.
REQ-036 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-037 LATENCY=2: SW addr 0x010 data 0xDEADBEEF accepted at edge k -> rsp_valid only in cycle after k+2, rsp_err=0, rsp_rdata=0; req_ready=0 from k to k+3.
REQ-038 After REQ-037, LW 0x010 -> rsp_rdata=0xDEADBEEF; LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
REQ-039 SB 0x011 data 0x00000055, then LW 0x010 -> 0xDEAD55EF; SH 0x012 data 0x00001234, then LW 0x010 -> 0x123455EF.
REQ-040 LW 0x012, LH 0x011, load funct3 011, and store funct3 100 -> each gives rsp_err=1, rsp_rdata=0; a following LW 0x010 is unchanged.
REQ-041 req_valid held high continuously with LATENCY=1 -> accepts exactly every 3 cycles, one rsp_valid pulse each; busy=1 between accepts.
REQ-042 SW 0x020 data 0x11111111 accepted, reset=0 one cycle later (before commit) -> no rsp_valid; after release, LW 0x020 returns its prior contents and req_ready=1 immediately.
